bist_scheduler: RTL
===================

Name: bist_scheduler

Overview:
Sequences BIST sessions over NUM_CUT circuits-under-test that share one BIST controller / pattern-generator / MISR engine.
- On start, selects each CUT in turn, pulses the engine's start, and waits for its end-of-session pulse.
- Compares the captured MISR signature with that CUT's golden value and accumulates a per-CUT pass mask.
- Sits between the top-level test access logic and the shared BIST controller.

Parameters:
NUM_CUT, 4, number of CUTs scheduled; must be >= 2.
SIG_W, 16, MISR signature width.
TIMEOUT, 1023, max cycles in WAIT before a session is declared hung; must be >= 1.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
start  in  1  request a full schedule; sampled only in IDLE with reset low.
golden  in  NUM_CUT*SIG_W  golden signatures; CUT i occupies bits [i*SIG_W +: SIG_W].
sess_end  in  1  end-of-session pulse from the BIST controller.
signature  in  SIG_W  MISR signature; valid in the cycle sess_end is high.
sess_start  out  1  one-cycle start pulse to the BIST controller.
cut_sel  out  $clog2(NUM_CUT)  current CUT index; drives the CUT mux.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the schedule completes.
pass_mask  out  NUM_CUT  bit i = CUT i passed.
all_pass  out  1  &pass_mask && !timeout_err; valid from the done cycle until the next start.
timeout_err  out  1  sticky; set when any session timed out.

Behaviour:
- Reset values: state IDLE; cut_sel 0; pass_mask 0; timeout_err 0; all_pass 0; sess_start 0; done 0; busy 0; timer 0; sig_q 0. Reset dominates every other input.
- States: IDLE, LAUNCH, WAIT, CHECK, NEXT, DONE. All outputs are registered or decoded from state only.
- IDLE:
  - Stays in IDLE while start=0.
  - start=1 -> LAUNCH on the same edge; cut_sel<=0, pass_mask<=0, timeout_err<=0, all_pass<=0.
- LAUNCH: sess_start=1 for exactly this cycle; timer<=0; -> WAIT.
- WAIT:
  - sess_end=1 -> CHECK; sig_q<=signature on the same edge.
  - Else if timer==TIMEOUT -> NEXT; pass_mask[cut_sel]<=0 and timeout_err<=1.
  - Else timer<=timer+1.
  - If sess_end and the timeout coincide, sess_end wins.
- CHECK: pass_mask[cut_sel] <= (sig_q == golden slice[cut_sel]); -> NEXT.
- NEXT:
  - cut_sel==NUM_CUT-1 -> DONE, with all_pass registered on that edge.
  - Else cut_sel<=cut_sel+1 and -> LAUNCH.
  - cut_sel never wraps mid-schedule.
- DONE: done=1 for exactly this cycle; -> IDLE. cut_sel holds its last value until the next start.
- Latency:
  - Per CUT: LAUNCH(1) + WAIT(k+1, where sess_end arrives k cycles after the WAIT entry) + CHECK(1) + NEXT(1).
  - With sess_end in the first WAIT cycle: 4 cycles per CUT; done at cycle 4*NUM_CUT+1 after the start edge.
- Timer: width $clog2(TIMEOUT+1); a timeout occurs after TIMEOUT+1 WAIT cycles.
- start while busy is ignored, with no restart and no state disturbance.
- sess_end outside WAIT is ignored.
- Reset mid-schedule: the next cycle is IDLE with all outputs at reset values; no done pulse is emitted.

Optional Feature:
Macro BIST_SCHED_RETRY_EN.
- When defined:
  - On a mismatch in CHECK, or a timeout in WAIT, the first failure of a given CUT returns to LAUNCH with the same cut_sel; pass_mask is not updated.
  - The retry session's result is final.
  - Adds output port retry_mask [NUM_CUT], cleared on start and reset; bit i is set when CUT i was retried.
  - timeout_err is set only on a timeout of the retry session.
- When undefined: no retry, no retry_mask port; behaviour exactly as above.

Decomposition:
- Shared include/package bist_pkg holds:
  - state encodings (IDLE_S..DONE_S, 3-bit) and the state width constant;
  - the default SIG_W;
  - the golden-slice indexing function.
  The BIST controller reuses SIG_W from it.
- One sub-module: bist_watchdog.
  - Parameter TIMEOUT; inputs clk, reset, clear, en; output expired.
  - Used for the WAIT timer.
- Comparison and FSM stay in bist_scheduler.

Test Plan:
Bench uses NUM_CUT=4, SIG_W=16, TIMEOUT=15, golden = {16'hD00D, 16'hBEEF, 16'h1234, 16'hA5A5} (CUT3..CUT0).
- Nominal pass: start pulse; the model returns sess_end in the first WAIT cycle with the matching signature -> 4 sess_start pulses with cut_sel 0,1,2,3; done at cycle 17; pass_mask=4'hF; all_pass=1.
- Mismatch: CUT2 returns 16'h1235 -> pass_mask=4'hB; all_pass=0; timeout_err=0.
- Timeout: CUT1 never asserts sess_end -> leaves WAIT after 16 cycles; pass_mask=4'hD; timeout_err=1; CUT2 and CUT3 still run; done asserted.
- Ignored inputs: start held high for the whole run -> exactly one schedule (4 sess_start pulses); sess_end pulsed in IDLE and LAUNCH -> no state change.
- Reset mid-run: reset during CUT2's WAIT -> next cycle busy=0, pass_mask=0, cut_sel=0, no done; a new start completes normally.
- Retry (macro on): CUT0 mismatches first, matches on retry -> 5 sess_start pulses; pass_mask=4'hF; retry_mask=4'h1.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions: scheduler state encoding, default signature width
// and golden-signature slice indexing. Also used by the BIST controller.
package bist_pkg;

  localparam int STATE_W   = 3;
  localparam int DEF_SIG_W = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE_S   = 3'd0,
    LAUNCH_S = 3'd1,
    WAIT_S   = 3'd2,
    CHECK_S  = 3'd3,
    NEXT_S   = 3'd4,
    DONE_S   = 3'd5
  } bist_state_t;

  // LSB position of CUT 'cut' inside the packed golden-signature vector.
  function automatic int golden_lsb(input int cut, input int sig_w);
    return cut * sig_w;
  endfunction

endpackage

// File: rtl/bist_watchdog.sv
// Session watchdog: counts enabled cycles from a clear and flags when the
// count reaches TIMEOUT, i.e. after TIMEOUT+1 enabled-or-expired cycles.
module bist_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      timer <= '0;
    end else if (en && !expired) begin
      timer <= timer + TW'(1);
    end
  end

  assign expired = (timer == TW'(TIMEOUT));

endmodule

// File: rtl/bist_scheduler.sv
// Schedules BIST sessions over NUM_CUT CUTs sharing one BIST engine and
// accumulates a per-CUT pass mask. Optional retry: define BIST_SCHED_RETRY_EN.
module bist_scheduler
  import bist_pkg::*;
#(
  parameter int NUM_CUT = 4,
  parameter int SIG_W   = DEF_SIG_W,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_CUT*SIG_W-1:0]   golden,
  input  logic                       sess_end,
  input  logic [SIG_W-1:0]           signature,
  output logic                       sess_start,
  output logic [$clog2(NUM_CUT)-1:0] cut_sel,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_CUT-1:0]         pass_mask,
  output logic                       all_pass,
  output logic                       timeout_err
`ifdef BIST_SCHED_RETRY_EN
  ,
  output logic [NUM_CUT-1:0]         retry_mask
`endif
);

  localparam int CUT_W = $clog2(NUM_CUT);

  bist_state_t      state, state_nxt;
  logic [SIG_W-1:0] sig_q;
  logic             expired, timer_clear, timer_en;
  logic             sig_match, last_cut, retried;

  bist_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .en      (timer_en),
    .expired (expired)
  );

  assign sig_match = (sig_q == golden[golden_lsb(int'(cut_sel), SIG_W) +: SIG_W]);
  assign last_cut  = (cut_sel == CUT_W'(NUM_CUT - 1));

  // A failure is final once the CUT has used its retry; without retry every
  // failure is final.
`ifdef BIST_SCHED_RETRY_EN
  assign retried = retry_mask[cut_sel];
`else
  assign retried = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE_S;
    else       state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state)
      IDLE_S:   if (start) state_nxt = LAUNCH_S;
      LAUNCH_S: begin
        timer_clear = 1'b1;
        state_nxt   = WAIT_S;
      end
      WAIT_S: begin
        if (sess_end)     state_nxt = CHECK_S;
        else if (expired) state_nxt = retried ? NEXT_S : LAUNCH_S;
        else              timer_en  = 1'b1;
      end
      CHECK_S:  state_nxt = (sig_match || retried) ? NEXT_S : LAUNCH_S;
      NEXT_S:   state_nxt = last_cut ? DONE_S : LAUNCH_S;
      DONE_S:   state_nxt = IDLE_S;
      default:  state_nxt = IDLE_S;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cut_sel     <= '0;
      pass_mask   <= '0;
      timeout_err <= 1'b0;
      all_pass    <= 1'b0;
      sig_q       <= '0;
    end else begin
      case (state)
        IDLE_S: if (start) begin
          cut_sel     <= '0;
          pass_mask   <= '0;
          timeout_err <= 1'b0;
          all_pass    <= 1'b0;
        end
        WAIT_S: begin
          if (sess_end) begin
            sig_q <= signature;
          end else if (expired && retried) begin
            pass_mask[cut_sel] <= 1'b0;
            timeout_err        <= 1'b1;
          end
        end
        CHECK_S: if (sig_match || retried) pass_mask[cut_sel] <= sig_match;
        NEXT_S: begin
          if (last_cut) all_pass <= &pass_mask && !timeout_err;
          else          cut_sel  <= cut_sel + CUT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BIST_SCHED_RETRY_EN
  logic retry_set;

  assign retry_set = !retried &&
                     (((state == WAIT_S) && !sess_end && expired) ||
                      ((state == CHECK_S) && !sig_match));

  always_ff @(posedge clk) begin
    if (reset)                         retry_mask          <= '0;
    else if ((state == IDLE_S) && start) retry_mask        <= '0;
    else if (retry_set)                retry_mask[cut_sel] <= 1'b1;
  end
`endif

  assign sess_start = (state == LAUNCH_S);
  assign busy       = (state != IDLE_S);
  assign done       = (state == DONE_S);

endmodule
